nested_width_channel: RTL and testbench
=======================================

Name: nested_width_channel

Overview:
- Streaming data holder built as two nesting levels.
- The inner level is a width-parameterised storage stage holding a data word `x`.
- The outer level instantiates exactly one inner stage at a fixed width of 32 and exposes that stage's contents to a downstream consumer port.
- It sits between a producer and a consumer as a 2-entry valid/ready skid buffer, giving full throughput and registered outputs.

Parameters:
- WIDTH, 32, data width of the inner storage stage. The outer level always instantiates it at 32; other values are legal only when the inner stage is used standalone.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in_valid  input  1  producer asserts when in_data is valid.
- in_ready  output  1  buffer can accept a word this cycle.
- in_data  input  WIDTH  producer data.
- out_valid  output  1  x holds a valid word.
- out_ready  input  1  consumer accepts x this cycle.
- x  output  WIDTH  head-of-buffer data word seen by the consumer.
- occupancy  output  2  number of words held (0..2).

Behaviour:
- Transfer rules:
  - Input transfer occurs when in_valid && in_ready at a rising edge.
  - Output transfer occurs when out_valid && out_ready at a rising edge.
- Storage: two registers, main (drives x) and skid, plus a 2-bit count.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - occupancy = count.
  - All outputs derive from registers only; there is no combinational path from in_* to out_* or from out_ready to in_ready.
- Reset (rst_n low, asynchronous, takes effect immediately without a clock edge):
  - count=0, main=0, skid=0.
  - Hence out_valid=0, x=0, in_ready=1, occupancy=0.
  - Deassertion is synchronised by the caller; the block takes no special action.
  - Reset asserted mid-transfer discards all held data; no partial words survive.
- Transitions (count before edge, push = input transfer, pop = output transfer):
  - 0, push: main<=in_data, count<=1.
  - 1, push only: skid<=in_data, count<=2.
  - 1, pop only: count<=0. x keeps its stale value, which consumers must ignore.
  - 1, push+pop: main<=in_data, count stays 1.
  - 2, pop: main<=skid, count<=1. No push is possible at count 2 because in_ready=0.
- Ordering: strict FIFO; words leave in arrival order with no duplication or loss.
- Latency: a word pushed into an empty buffer appears on x with out_valid=1 on the cycle after the push edge (1-cycle latency).
- Throughput: with out_ready held high, one word per cycle.
- Backpressure: with out_ready low, x and out_valid stay stable until popped (AXI-style hold).
- Width rule: in_data, x, main and skid are all exactly WIDTH bits with no truncation or extension. At the outer level WIDTH=32, so x is logic [31:0].
- in_data is ignored when in_ready=0 or in_valid=0.

Decomposition:
- Shared package nested_width_pkg:
  - localparam DATA_W = 32
  - typedef logic [DATA_W-1:0] data_t
  - typedef logic [1:0] occ_t
- Sub-module width_param_store #(WIDTH): the inner parameterised storage stage (main/skid registers and count, with the full handshake logic above).
- nested_width_channel is the outer wrapper. It instantiates width_param_store #(.WIDTH(DATA_W)) once and forwards its x/out_valid/out_ready to the consumer port unchanged.

Test Plan:
- Reset check: assert rst_n=0 with no clock edge -> x=0, out_valid=0, in_ready=1 and occupancy=0 immediately.
- Single word: push 32'hDEADBEEF with out_ready=0 -> next cycle out_valid=1, x=32'hDEADBEEF, occupancy=1, in_ready=1.
- Fill and stall: with out_ready=0, push 32'h1 then 32'h2 -> occupancy=2, in_ready=0. A third in_valid with 32'h3 is not accepted.
- Drain in order: from the full state set out_ready=1 -> x=32'h1 then 32'h2 on consecutive cycles, then out_valid=0.
- Streaming: in_valid=1 and out_ready=1 continuously with data 0..99 -> consumer receives 0..99 in order, one per cycle, in_ready never drops.
- Mid-operation reset: at occupancy=2 with x=32'hA5A5A5A5, pulse rst_n low between clock edges -> x=0, out_valid=0 and occupancy=0 immediately. After release, a push of 32'h7 appears alone.

Source files
------------

// File: rtl/nested_width_pkg.sv
// Shared types and constants for the nested width channel.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package nested_width_pkg;

    // Width at which the outer channel instantiates its storage stage
    localparam int DATA_W = 32;

    // Number of words the skid buffer can hold
    localparam int DEPTH = 2;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [1:0]        occ_t;

    // Occupancy encodings used by the storage stage
    localparam occ_t OCC_EMPTY = 2'd0;
    localparam occ_t OCC_ONE   = 2'd1;
    localparam occ_t OCC_FULL  = 2'd2;

endpackage

// File: rtl/width_param_store.sv
// Width-parameterised 2-entry valid/ready skid buffer (main + skid registers).
// Latency: 1 cycle from an input transfer into an empty buffer to out_valid/x.
// Backpressure: in_ready drops only when both entries are held; outputs hold until popped.
module width_param_store
    import nested_width_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x,
    output occ_t             occupancy
);

    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    occ_t             count_q;
    logic             push;
    logic             pop;

    // Handshake flags come only from registered state, so there is no
    // combinational path from in_* to out_* or from out_ready to in_ready.
    assign in_ready  = (count_q != OCC_FULL);
    assign out_valid = (count_q != OCC_EMPTY);
    assign occupancy = count_q;
    assign x         = main_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // Storage update: main always holds the oldest word, skid the second one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q  <= '0;
            skid_q  <= '0;
            count_q <= OCC_EMPTY;
        end else begin
            case (count_q)
                OCC_EMPTY: begin
                    if (push) begin
                        main_q  <= in_data;
                        count_q <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        // Head leaves while the new word takes its place
                        main_q <= in_data;
                    end else if (push) begin
                        skid_q  <= in_data;
                        count_q <= OCC_FULL;
                    end else if (pop) begin
                        // main keeps its stale value; out_valid=0 masks it
                        count_q <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        main_q  <= skid_q;
                        count_q <= OCC_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to empty
                    count_q <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule

// File: rtl/nested_width_channel.sv
// Outer channel wrapping one 32-bit skid-buffer storage stage.
// Latency: 1 cycle from input transfer into an empty buffer to x/out_valid.
// Backpressure: full throughput; in_ready drops only when 2 words are held.
module nested_width_channel
    import nested_width_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t x,
    output occ_t  occupancy
);

    // Single storage stage fixed at the package data width; consumer-side
    // signals are forwarded without any added logic.
    width_param_store #(
        .WIDTH (DATA_W)
    ) u_store (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .occupancy (occupancy)
    );

endmodule

// File: tb/tb_nested_width_channel.sv
// Directed bench for nested_width_channel: reset, single word, fill/stall,
// ordered drain, 100-word streaming and asynchronous mid-operation reset.
module tb_nested_width_channel;
    import nested_width_pkg::*;

    logic  clk;
    logic  rst_n;
    logic  in_valid;
    logic  in_ready;
    data_t in_data;
    logic  out_valid;
    logic  out_ready;
    data_t x;
    occ_t  occupancy;

    int tests;
    int failed;

    nested_width_channel dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset takes effect with no clock edge (first posedge at t=5)
        #2 rst_n = 1'b0;
        #1;
        check("rst_x",         x,         32'h0);
        check("rst_out_valid", out_valid, 32'h0);
        check("rst_in_ready",  in_ready,  32'h1);
        check("rst_occ",       occupancy, 32'h0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_occ", occupancy, 32'h0);

        // Single word with consumer stalled
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        step();
        in_valid = 1'b0;
        in_data  = 32'hFFFF_FFFF;
        check("single_out_valid", out_valid, 32'h1);
        check("single_x",         x,         32'hDEADBEEF);
        check("single_occ",       occupancy, 32'h1);
        check("single_in_ready",  in_ready,  32'h1);
        step();
        check("single_hold_x", x, 32'hDEADBEEF);

        // Pop it; x keeps the stale word
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop1_out_valid", out_valid, 32'h0);
        check("pop1_occ",       occupancy, 32'h0);
        check("pop1_stale_x",   x,         32'hDEADBEEF);

        // Fill and stall
        in_valid = 1'b1;
        in_data  = 32'h1;
        step();
        in_data  = 32'h2;
        step();
        check("fill_occ",      occupancy, 32'h2);
        check("fill_in_ready", in_ready,  32'h0);
        check("fill_x",        x,         32'h1);
        in_data = 32'h3;
        step();
        check("stall_occ", occupancy, 32'h2);
        check("stall_x",   x,         32'h1);
        in_valid = 1'b0;

        // Drain in order
        out_ready = 1'b1;
        step();
        check("drain1_x",   x,         32'h2);
        check("drain1_occ", occupancy, 32'h1);
        check("drain1_in_ready", in_ready, 32'h1);
        step();
        check("drain2_out_valid", out_valid, 32'h0);
        check("drain2_occ",       occupancy, 32'h0);

        // Streaming 0..99 with consumer always ready
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1;
            in_data  = i;
            step();
            check("stream_x",         x,         i);
            check("stream_out_valid", out_valid, 32'h1);
            check("stream_in_ready",  in_ready,  32'h1);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_out_valid", out_valid, 32'h0);
        check("stream_end_occ",       occupancy, 32'h0);

        // Mid-operation asynchronous reset at full occupancy
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'hA5A5A5A5;
        step();
        in_data   = 32'h5A5A5A5A;
        step();
        in_valid  = 1'b0;
        check("pre_rst_occ", occupancy, 32'h2);
        check("pre_rst_x",   x,         32'hA5A5A5A5);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_x",         x,         32'h0);
        check("mid_rst_out_valid", out_valid, 32'h0);
        check("mid_rst_occ",       occupancy, 32'h0);
        check("mid_rst_in_ready",  in_ready,  32'h1);
        #1 rst_n = 1'b1;
        step();
        check("after_rst_occ", occupancy, 32'h0);

        // A single push after reset appears alone
        in_valid = 1'b1;
        in_data  = 32'h7;
        step();
        in_valid = 1'b0;
        check("after_rst_x",   x,         32'h7);
        check("after_rst_occ1", occupancy, 32'h1);
        out_ready = 1'b1;
        step();
        check("after_rst_empty_valid", out_valid, 32'h0);
        check("after_rst_empty_occ",   occupancy, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
